// File: rtl/fifo_burst_reader_pkg.sv
// Shared widths, hold-stage state encoding and counter helper for the FIFO burst reader.
package fifo_burst_reader_pkg;

  localparam int CNT_W   = 16;
  localparam int STATS_W = 32;

  typedef enum logic [1:0] {
    H_EMPTY,
    H_PENDING,
    H_READY
  } hold_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v == lim) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_stream_out.sv
// Output register slice: holds data/last stable while the consumer stalls, accepts a refill on transfer.
module stream_out_reg_m
  import fifo_burst_reader_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         m_ready,
  output logic         can_load,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  output logic         m_last
);

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } entry_t;

  entry_t o_q, o_d;
  logic   valid_q, valid_d;

  always_comb begin
    o_d     = o_q;
    valid_d = valid_q;
    if (load) begin
      o_d.data = in_data;
      o_d.last = in_last;
      valid_d  = 1'b1;
    end else if (m_ready) begin
      o_d.last = 1'b0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      valid_q <= valid_d;
    end
  end

  assign can_load = !valid_q | m_ready;
  assign m_data   = o_q.data;
  assign m_valid  = valid_q;
  assign m_last   = o_q.last;

endmodule

// File: rtl/fifo_burst_reader_m.sv
// FWFT FIFO drain that frames items into bursts (BURST_LEN beats or idle timeout).
// Optional beat/flush statistics ports are enabled with FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader_m
  import fifo_burst_reader_pkg::*;
#(
  parameter type DATA_ITEM_TYPE = logic,
  parameter int  BURST_LEN      = 16,
  parameter int  TIMEOUT        = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [$bits(DATA_ITEM_TYPE)-1:0] head,
  input  logic                             empty,
  input  logic                             rd_rst_busy,
  output logic                             pop,
  output logic [$bits(DATA_ITEM_TYPE)-1:0] m_data,
  output logic                             m_valid,
  output logic                             m_last,
  input  logic                             m_ready
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [STATS_W-1:0]               bursts_cnt,
  output logic [STATS_W-1:0]               flush_cnt
`endif
);

  localparam int W = $bits(DATA_ITEM_TYPE);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] TIMER_LIM = CNT_W'(TIMEOUT);

  logic             hv_q, hv_d;
  logic [W-1:0]     h_data_q, h_data_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic        avail, at_end, expired, h_last, h_move, o_can_load;
  hold_state_e h_state;

  always_comb begin
    avail   = !empty & !rd_rst_busy;
    at_end  = (beat_q == LAST_BEAT);
    expired = (timer_q == TIMER_LIM);
    h_last  = at_end | expired;

    // An item may leave H once its last flag is known: either the burst is full,
    // the idle timer fired, or a follower is already waiting in the FIFO.
    if (!hv_q)                        h_state = H_EMPTY;
    else if (at_end | avail | expired) h_state = H_READY;
    else                              h_state = H_PENDING;

    h_move = (h_state == H_READY) & o_can_load;
    pop    = avail & (!hv_q | h_move) & !rst;

    hv_d     = pop ? 1'b1 : (h_move ? 1'b0 : hv_q);
    h_data_d = pop ? head : h_data_q;

    beat_d = beat_q;
    if (h_move) beat_d = h_last ? '0 : beat_q + CNT_W'(1);

    timer_d = timer_q;
    if (pop | h_move)          timer_d = '0;
    else if (hv_q & !avail)    timer_d = sat_inc(timer_q, TIMER_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv_q     <= 1'b0;
      h_data_q <= '0;
      beat_q   <= '0;
      timer_q  <= '0;
    end else begin
      hv_q     <= hv_d;
      h_data_q <= h_data_d;
      beat_q   <= beat_d;
      timer_q  <= timer_d;
    end
  end

  stream_out_reg_m #(.W(W)) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (h_move),
    .in_data  (h_data_q),
    .in_last  (h_last),
    .m_ready  (m_ready),
    .can_load (o_can_load),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last)
  );

`ifdef FIFO_BURST_READER_STATS_EN
  logic [STATS_W-1:0] bursts_q, bursts_d, flush_q, flush_d;

  always_comb begin
    bursts_d = bursts_q;
    flush_d  = flush_q;
    if (m_valid & m_ready & m_last) bursts_d = bursts_q + STATS_W'(1);
    // Only closures caused purely by the idle timer count as flushes.
    if (h_move & expired & !at_end) flush_d = flush_q + STATS_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bursts_q <= '0;
      flush_q  <= '0;
    end else begin
      bursts_q <= bursts_d;
      flush_q  <= flush_d;
    end
  end

  assign bursts_cnt = bursts_q;
  assign flush_cnt  = flush_q;
`endif

endmodule

// File: doc/fifo_burst_reader_m.md
Name: fifo_burst_reader_m

Overview:
- Drain side of the single-clock FWFT FIFO wrapper.
- Pops items through the FIFO's head/empty/pop interface and re-emits them as a valid/ready stream, framed into bursts with a last flag.
- A burst closes after BURST_LEN beats, or early when the FIFO stays empty for TIMEOUT cycles.
- Sits between the FIFO and downstream packetising logic (DMA/AXI-Stream style consumers).

Parameters:
- DATA_ITEM_TYPE, logic, item type; must match the FIFO's item type.
- BURST_LEN, 16, maximum beats per burst; legal range 1 to 65535.
- TIMEOUT, 64, number of idle cycles with the FIFO empty before a partial burst is closed; legal range 1 to 65535.

Ports:
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset; asynchronous, active-high.
- head  in  $bits(DATA_ITEM_TYPE)  FIFO output item (FWFT, valid when empty=0).
- empty  in  1  FIFO empty.
- rd_rst_busy  in  1  FIFO read-side reset in progress.
- pop  out  1  FIFO read enable.
- m_data  out  $bits(DATA_ITEM_TYPE)  stream data.
- m_valid  out  1  stream valid.
- m_last  out  1  last beat of the burst.
- m_ready  in  1  downstream ready.

Behaviour:
- Reset values: pop=0, m_valid=0, m_last=0, m_data=0. All internal state clears: hold register, beat counter, idle timer.
- Reset is asynchronous. Asserting it mid-burst drops both held items immediately; no last beat is emitted. After release, the next item starts a new burst at beat 0.
- avail = !empty & !rd_rst_busy. While rd_rst_busy=1, pop=0 and the FIFO is treated as empty.
- Two registers sit in series:
  - H (hold): one item, flag hv.
  - O (output): drives m_data/m_valid/m_last.
- pop = avail & (!hv | h_move). This is combinational, and the popped head is captured into H on the same edge.
- State per H:
  - EMPTY (hv=0).
  - PENDING (hv=1, last not yet decided).
  - READY (hv=1, decided).
- Decision for the item in H:
  - decided = (beat_cnt == BURST_LEN-1) | avail | expired.
  - Its last value = (beat_cnt == BURST_LEN-1) | expired.
  - Expiry wins over newly arriving data.
- h_move = hv & decided & (!m_valid | m_ready). On h_move, O takes H and its last value, m_valid=1 next cycle.
- beat_cnt (16 bit): increments on h_move; clears to 0 on an h_move with last=1.
- Idle timer (16 bit):
  - Clears when H loads.
  - Increments each cycle with hv & !avail; saturates at TIMEOUT.
  - expired = (timer == TIMEOUT).
  - Once expired, it stays expired until H moves, even if data arrives.
- Stream handshake:
  - m_valid and m_data are stable while m_valid & !m_ready.
  - A beat transfers on m_valid & m_ready.
  - O clears after the transfer unless refilled by h_move in the same cycle.
- Latency: head present with empty=0 at cycle t, and a second item available at t+1 → first beat has m_valid=1 at t+2.
- Throughput: one beat per cycle when the FIFO is non-empty and m_ready=1.
- BURST_LEN=1: every beat has last=1; timer is irrelevant.
- Backpressure: with m_ready=0, at most 2 items are removed from the FIFO (H and O), then pop=0.
- The block never pops while empty=1. No underflow is possible.

Optional Feature:
- Macro: FIFO_BURST_READER_STATS_EN.
- When defined, two output ports are added, each a 32-bit wrapping counter that clears on rst:
  - bursts_cnt: increments on each transferred beat with m_last=1.
  - flush_cnt: increments on each h_move whose last was caused by expiry and not by beat count.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fifo_burst_reader_pkg:
  - CNT_W=16 (beat and timer counter width).
  - STATS_W=32.
  - typedef for the H/O register entry: struct { DATA_ITEM_TYPE-agnostic data bits, last }, parameterised via a width localparam in the module.
- One sub-module is natural: stream_out_reg_m, the O-stage register slice with valid/ready hold semantics. The hold/decision/timer logic stays in the top.

Test Plan (BURST_LEN=4, TIMEOUT=8 unless stated):
- Preload 8 items 0..7, m_ready=1 → beats 0..7 back to back; m_last on items 3 and 7 only; first m_valid 2 cycles after the first pop.
- Preload 2 items, no further writes → beat 0 with last=0; beat 1 with last=1 exactly 8 idle cycles after H loads; flush_cnt=1 when stats are enabled.
- Write item 9 at idle cycle 5 after item 8 enters H → item 8 goes out with last=0; the burst continues; beat_cnt=2 after item 9 moves.
- Preload 6 items, m_ready=0 for 20 cycles → exactly 2 pops, m_data stable at item 0; release ready → all 6 out in order, last on item 3.
- rd_rst_busy=1 with FIFO non-empty for 10 cycles → pop=0 throughout; H expires a pending item as last if hv=1.
- Assert rst mid-burst after 2 of 4 beats → m_valid drops asynchronously; after release, a fresh burst runs 4 beats with last on the 4th.
